// File: rtl/arb_types_pkg.sv
// Shared types for the mem_arbiter slice: FSM states, RAM op encoding, data-streak sizing.
// Optional performance counters are enabled with the ARB_PERF_EN macro.
package arb_types_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        IBUSY = 2'd1,
        DBUSY = 2'd2
    } arb_state_t;

    typedef enum logic {
        OP_READ  = 1'b0,
        OP_WRITE = 1'b1
    } arb_op_t;

    // Four bits cover the legal MAX_DSTREAK range of 1..15.
    localparam int DSTREAK_W = 4;

    function automatic logic [DSTREAK_W-1:0] streak_next(
        input logic [DSTREAK_W-1:0] cur,
        input logic [DSTREAK_W-1:0] max_val
    );
        logic [DSTREAK_W-1:0] res;
        if (cur >= max_val) begin
            res = max_val;
        end else begin
            res = cur + {{(DSTREAK_W-1){1'b0}}, 1'b1};
        end
        return res;
    endfunction

endpackage

// File: rtl/arb_perf_counters.sv
// Hit and stall event counters for mem_arbiter; instantiated only when ARB_PERF_EN is defined.
module arb_perf_counters (
    input  logic        clk,
    input  logic        rst,
    input  logic        ihit,
    input  logic        dhit,
    input  logic        stall,
    output logic [31:0] icnt,
    output logic [31:0] dcnt,
    output logic [31:0] stallcnt
);

    // Free-running wrap-around event counters.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            icnt     <= 32'd0;
            dcnt     <= 32'd0;
            stallcnt <= 32'd0;
        end else begin
            if (ihit) begin
                icnt <= icnt + 32'd1;
            end
            if (dhit) begin
                dcnt <= dcnt + 32'd1;
            end
            if (stall) begin
                stallcnt <= stallcnt + 32'd1;
            end
        end
    end

endmodule

// File: rtl/mem_arbiter.sv
// Arbitrates instruction-fetch and load/store ports onto one variable-latency RAM.
// Define ARB_PERF_EN to build the icnt/dcnt/stallcnt performance counters.
import arb_types_pkg::*;

module mem_arbiter #(
    parameter int WORD_W      = 32,
    parameter int MAX_DSTREAK = 4
) (
    input  logic              CLK,
    input  logic              RST,
    input  logic              iREN,
    input  logic [WORD_W-1:0] iaddr,
    output logic [WORD_W-1:0] iload,
    output logic              ihit,
    input  logic              dREN,
    input  logic              dWEN,
    input  logic [WORD_W-1:0] daddr,
    input  logic [WORD_W-1:0] dstore,
    output logic [WORD_W-1:0] dload,
    output logic              dhit,
    input  logic              halt,
    output logic              ram_REN,
    output logic              ram_WEN,
    output logic [WORD_W-1:0] ram_addr,
    output logic [WORD_W-1:0] ram_store,
    input  logic [WORD_W-1:0] ram_load,
    input  logic              ram_rdy,
    output logic [31:0]       icnt,
    output logic [31:0]       dcnt,
    output logic [31:0]       stallcnt
);

    localparam logic [DSTREAK_W-1:0] MAX_STREAK = DSTREAK_W'(MAX_DSTREAK);

    arb_state_t           state_r;
    arb_state_t           state_nx_s;
    arb_op_t              op_r;
    logic [DSTREAK_W-1:0] dstreak_r;
    logic [DSTREAK_W-1:0] dstreak_nx_s;
    logic                 i_elig_s;
    logic                 d_elig_s;
    logic                 grant_i_s;
    logic                 grant_d_s;
    logic                 unused_addr_bits_s;

    // RAM is word addressed; the byte-offset bits are dropped on grant.
    assign unused_addr_bits_s = ^{iaddr[1:0], daddr[1:0]};

    // A port that is completing this cycle cannot be re-granted until the next one.
    assign i_elig_s = iREN & ~ihit & ~halt;
    assign d_elig_s = (dREN | dWEN) & ~dhit & ~halt;

    // Arbitration and next-state decode.
    always_comb begin
        state_nx_s = state_r;
        grant_i_s  = 1'b0;
        grant_d_s  = 1'b0;
        case (state_r)
            IDLE: begin
                if (i_elig_s && (dstreak_r == MAX_STREAK)) begin
                    grant_i_s = 1'b1;
                end else if (d_elig_s) begin
                    grant_d_s = 1'b1;
                end else if (i_elig_s) begin
                    grant_i_s = 1'b1;
                end else begin
                    grant_i_s = 1'b0;
                end
                if (grant_i_s) begin
                    state_nx_s = IBUSY;
                end else if (grant_d_s) begin
                    state_nx_s = DBUSY;
                end else begin
                    state_nx_s = IDLE;
                end
            end
            IBUSY, DBUSY: begin
                if (ram_rdy) begin
                    state_nx_s = IDLE;
                end else begin
                    state_nx_s = state_r;
                end
            end
            default: begin
                state_nx_s = IDLE;
            end
        endcase
    end

    // Data-streak tracking; a halted IDLE cycle with iREN high leaves the streak untouched.
    always_comb begin
        dstreak_nx_s = dstreak_r;
        if (state_r == IDLE) begin
            if (grant_i_s) begin
                dstreak_nx_s = {DSTREAK_W{1'b0}};
            end else if (grant_d_s && iREN) begin
                dstreak_nx_s = streak_next(dstreak_r, MAX_STREAK);
            end else if (!iREN) begin
                dstreak_nx_s = {DSTREAK_W{1'b0}};
            end else begin
                dstreak_nx_s = dstreak_r;
            end
        end else begin
            dstreak_nx_s = dstreak_r;
        end
    end

    // State, transaction registers, RAM strobes and completion outputs.
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            state_r   <= IDLE;
            op_r      <= OP_READ;
            dstreak_r <= {DSTREAK_W{1'b0}};
            ram_REN   <= 1'b0;
            ram_WEN   <= 1'b0;
            ram_addr  <= {WORD_W{1'b0}};
            ram_store <= {WORD_W{1'b0}};
            ihit      <= 1'b0;
            dhit      <= 1'b0;
            iload     <= {WORD_W{1'b0}};
            dload     <= {WORD_W{1'b0}};
        end else begin
            state_r   <= state_nx_s;
            dstreak_r <= dstreak_nx_s;
            ihit      <= 1'b0;
            dhit      <= 1'b0;
            case (state_r)
                IDLE: begin
                    if (grant_i_s) begin
                        op_r     <= OP_READ;
                        ram_addr <= {iaddr[WORD_W-1:2], 2'b00};
                        ram_REN  <= 1'b1;
                        ram_WEN  <= 1'b0;
                    end else if (grant_d_s) begin
                        ram_addr  <= {daddr[WORD_W-1:2], 2'b00};
                        ram_store <= dstore;
                        if (dWEN) begin
                            op_r    <= OP_WRITE;
                            ram_REN <= 1'b0;
                            ram_WEN <= 1'b1;
                        end else begin
                            op_r    <= OP_READ;
                            ram_REN <= 1'b1;
                            ram_WEN <= 1'b0;
                        end
                    end else begin
                        ram_REN <= 1'b0;
                        ram_WEN <= 1'b0;
                    end
                end
                IBUSY: begin
                    if (ram_rdy) begin
                        ram_REN <= 1'b0;
                        ram_WEN <= 1'b0;
                        ihit    <= 1'b1;
                        iload   <= ram_load;
                    end
                end
                DBUSY: begin
                    if (ram_rdy) begin
                        ram_REN <= 1'b0;
                        ram_WEN <= 1'b0;
                        dhit    <= 1'b1;
                        if (op_r == OP_READ) begin
                            dload <= ram_load;
                        end
                    end
                end
                default: begin
                    ram_REN <= 1'b0;
                    ram_WEN <= 1'b0;
                end
            endcase
        end
    end

`ifdef ARB_PERF_EN
    logic stall_s;

    assign stall_s = (iREN | dREN | dWEN) & ~(ihit | dhit);

    arb_perf_counters u_perf (
        .clk      (CLK),
        .rst      (RST),
        .ihit     (ihit),
        .dhit     (dhit),
        .stall    (stall_s),
        .icnt     (icnt),
        .dcnt     (dcnt),
        .stallcnt (stallcnt)
    );
`else
    assign icnt     = 32'd0;
    assign dcnt     = 32'd0;
    assign stallcnt = 32'd0;
`endif

endmodule

// File: tb/tb_mem_arbiter.sv
// Directed self-checking bench for mem_arbiter: vector table plus multi-cycle corner sequences.
module tb_mem_arbiter;

    logic        CLK = 1'b0;
    logic        RST;
    logic        iREN, dREN, dWEN, halt, ram_rdy;
    logic [31:0] iaddr, daddr, dstore, ram_load;
    logic [31:0] iload, dload, ram_addr, ram_store, icnt, dcnt, stallcnt;
    logic        ihit, dhit, ram_REN, ram_WEN;

    int checks   = 0;
    int failures = 0;

    int          ram_lat  = 1;
    logic [31:0] ram_data = 32'd0;
    int          busy_cnt = 0;
    int          dhit_total = 0;
    int          hit_order[$];

    mem_arbiter #(.WORD_W(32), .MAX_DSTREAK(4)) dut (
        .CLK(CLK), .RST(RST),
        .iREN(iREN), .iaddr(iaddr), .iload(iload), .ihit(ihit),
        .dREN(dREN), .dWEN(dWEN), .daddr(daddr), .dstore(dstore), .dload(dload), .dhit(dhit),
        .halt(halt),
        .ram_REN(ram_REN), .ram_WEN(ram_WEN), .ram_addr(ram_addr), .ram_store(ram_store),
        .ram_load(ram_load), .ram_rdy(ram_rdy),
        .icnt(icnt), .dcnt(dcnt), .stallcnt(stallcnt)
    );

    always #5 CLK = ~CLK;

    typedef struct {
        logic        iren;
        logic [31:0] iaddr;
        logic        dren;
        logic        dwen;
        logic [31:0] daddr;
        logic [31:0] dstore;
        int          lat;
        logic [31:0] rdata;
        logic [31:0] exp_addr;
        logic        exp_ren;
        logic        exp_wen;
        logic        is_d;
        logic [31:0] exp_load;
    } vec_t;

    vec_t vecs[6];

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", name, got, exp);
        end
    endtask

    // RAM model: ready on the ram_lat-th strobed cycle, with ram_data as read data.
    initial begin
        ram_rdy  = 1'b0;
        ram_load = 32'd0;
        forever begin
            @(negedge CLK);
            if (ram_REN || ram_WEN) begin
                busy_cnt++;
                ram_rdy  = (busy_cnt == ram_lat);
                ram_load = ram_data;
            end else begin
                busy_cnt = 0;
                ram_rdy  = 1'b0;
            end
        end
    end

    // Completion monitor: port order (0 = I, 1 = D) and total data hits.
    initial begin
        forever begin
            @(negedge CLK);
            if (ihit) hit_order.push_back(0);
            if (dhit) begin
                hit_order.push_back(1);
                dhit_total++;
            end
        end
    end

    initial begin
        #400000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog expired");
    end

    task automatic clear_inputs();
        iREN = 1'b0; dREN = 1'b0; dWEN = 1'b0; halt = 1'b0;
        iaddr = 32'd0; daddr = 32'd0; dstore = 32'd0;
    endtask

    task automatic run_vec(input vec_t v);
        @(negedge CLK);
        iREN = v.iren; iaddr = v.iaddr; dREN = v.dren; dWEN = v.dwen;
        daddr = v.daddr; dstore = v.dstore; ram_lat = v.lat; ram_data = v.rdata;
        @(negedge CLK);
        check("grant_addr", ram_addr, v.exp_addr);
        check("grant_strobes", 32'({ram_REN, ram_WEN}), 32'({v.exp_ren, v.exp_wen}));
        check("grant_nohit", 32'({ihit, dhit}), 32'd0);
        if (v.exp_wen) check("grant_store", ram_store, v.dstore);
        // Withdraw the request and scramble addresses; the transaction must not notice.
        iREN = 1'b0; dREN = 1'b0; dWEN = 1'b0;
        iaddr = 32'hBAD0_0000; daddr = 32'hBAD1_0000; dstore = 32'h0;
        for (int k = 1; k < v.lat; k++) begin
            @(negedge CLK);
            check("busy_addr", ram_addr, v.exp_addr);
            check("busy_strobes", 32'({ram_REN, ram_WEN}), 32'({v.exp_ren, v.exp_wen}));
            check("busy_nohit", 32'({ihit, dhit}), 32'd0);
        end
        @(negedge CLK);
        check("hit", 32'({ihit, dhit}), v.is_d ? 32'd1 : 32'd2);
        check("idle_strobes", 32'({ram_REN, ram_WEN}), 32'd0);
        if (v.is_d) check("dload", dload, v.exp_load);
        else        check("iload", iload, v.exp_load);
        @(negedge CLK);
        check("hit_one_cycle", 32'({ihit, dhit}), 32'd0);
    endtask

    task automatic wait_hit(input logic want_d, input int maxc, output int cyc);
        cyc = -1;
        for (int c = 1; c <= maxc; c++) begin
            @(negedge CLK);
            if ((want_d && dhit) || (!want_d && ihit)) begin
                cyc = c;
                break;
            end
        end
        if (cyc < 0) check(want_d ? "dhit_timeout" : "ihit_timeout", 32'd0, 32'd1);
    endtask

    initial begin
        int cyc_d, cyc_i, hits, base;
        int exp_order[10];

        //              iren  iaddr          dren  dwen  daddr          dstore         lat rdata          exp_addr       ren   wen   is_d  exp_load
        vecs[0] = '{1'b1, 32'h0000_0104, 1'b0, 1'b0, 32'h0,         32'h0,         1, 32'hDEAD_BEEF, 32'h0000_0104, 1'b1, 1'b0, 1'b0, 32'hDEAD_BEEF};
        vecs[1] = '{1'b0, 32'h0,         1'b1, 1'b0, 32'h0000_1007, 32'h0,         2, 32'hCAFE_F00D, 32'h0000_1004, 1'b1, 1'b0, 1'b1, 32'hCAFE_F00D};
        vecs[2] = '{1'b0, 32'h0,         1'b1, 1'b1, 32'h0000_0203, 32'h1234_5678, 3, 32'h5555_5555, 32'h0000_0200, 1'b0, 1'b1, 1'b1, 32'hCAFE_F00D};
        vecs[3] = '{1'b1, 32'hFFFF_FFFF, 1'b0, 1'b0, 32'h0,         32'h0,         1, 32'h0000_0000, 32'hFFFF_FFFC, 1'b1, 1'b0, 1'b0, 32'h0000_0000};
        vecs[4] = '{1'b0, 32'h0,         1'b1, 1'b0, 32'h0000_0000, 32'h0,         4, 32'hA5A5_5A5A, 32'h0000_0000, 1'b1, 1'b0, 1'b1, 32'hA5A5_5A5A};
        vecs[5] = '{1'b0, 32'h0,         1'b0, 1'b1, 32'h8000_0001, 32'hFFFF_FFFF, 1, 32'h0BAD_0BAD, 32'h8000_0000, 1'b0, 1'b1, 1'b1, 32'hA5A5_5A5A};

        clear_inputs();
        RST = 1'b1;
        repeat (2) @(negedge CLK);
        check("rst_hits", 32'({ihit, dhit}), 32'd0);
        check("rst_strobes", 32'({ram_REN, ram_WEN}), 32'd0);
        check("rst_addr", ram_addr, 32'd0);
        check("rst_store", ram_store, 32'd0);
        check("rst_loads", iload | dload, 32'd0);
        check("rst_counters", icnt | dcnt | stallcnt, 32'd0);
        RST = 1'b0;
        @(negedge CLK);

        for (int i = 0; i < 6; i++) run_vec(vecs[i]);

`ifdef ARB_PERF_EN
        check("icnt", icnt, 32'd2);
        check("dcnt", dcnt, 32'd4);
`endif

        // Simultaneous I and D requests: data first, instruction granted in the dhit cycle.
        @(negedge CLK);
        iREN = 1'b1; iaddr = 32'h0000_0040; dREN = 1'b1; daddr = 32'h0000_0080;
        ram_lat = 2; ram_data = 32'h1111_2222;
        @(negedge CLK);
        check("both_first_addr", ram_addr, 32'h0000_0080);
        wait_hit(1'b1, 10, cyc_d);
        dREN = 1'b0;
        check("both_dhit_cycle", 32'(cyc_d), 32'd2);
        @(negedge CLK);
        check("both_second_addr", ram_addr, 32'h0000_0040);
        check("both_second_ren", 32'(ram_REN), 32'd1);
        wait_hit(1'b0, 10, cyc_i);
        iREN = 1'b0;
        check("both_ihit_cycle", 32'(cyc_i), 32'd2);
        check("both_iload", iload, 32'h1111_2222);
        repeat (2) @(negedge CLK);

        // Data streak: halt during each dhit cycle so the instruction only wins once forced.
        exp_order = '{1, 1, 1, 1, 0, 1, 1, 1, 1, 0};
        hit_order.delete();
        ram_lat = 1; ram_data = 32'h0;
        @(negedge CLK);
        iREN = 1'b1; iaddr = 32'h0000_0500; dWEN = 1'b1; daddr = 32'h0000_0300; dstore = 32'h0;
        for (int c = 0; c < 200; c++) begin
            @(negedge CLK);
            halt = dhit;
            if (hit_order.size() >= 10) break;
        end
        clear_inputs();
        check("streak_hit_count", 32'(hit_order.size()), 32'd10);
        hits = (hit_order.size() < 10) ? hit_order.size() : 10;
        for (int k = 0; k < hits; k++) check("streak_order", 32'(hit_order[k]), 32'(exp_order[k]));
        repeat (3) @(negedge CLK);
        check("streak_quiet", 32'({ram_REN, ram_WEN}), 32'd0);

        // Async reset during DBUSY: strobes drop at once and no dhit follows.
        @(negedge CLK);
        dWEN = 1'b1; daddr = 32'h0000_0600; dstore = 32'hFACE_0000; ram_lat = 10;
        @(negedge CLK);
        check("rstmid_wen_before", 32'(ram_WEN), 32'd1);
        dWEN = 1'b0;
        base = dhit_total;
        @(negedge CLK);
        RST = 1'b1;
        #1;
        check("rstmid_strobes", 32'({ram_REN, ram_WEN}), 32'd0);
        check("rstmid_addr", ram_addr, 32'd0);
`ifdef ARB_PERF_EN
        check("rstmid_counters", icnt | dcnt | stallcnt, 32'd0);
`endif
        @(negedge CLK);
        RST = 1'b0;
        repeat (12) @(negedge CLK);
        check("rstmid_no_dhit", 32'(dhit_total - base), 32'd0);
        run_vec(vecs[0]);

        // halt with an in-flight data read: the read completes, nothing new is issued.
        @(negedge CLK);
        dREN = 1'b1; daddr = 32'h0000_0700; ram_lat = 3; ram_data = 32'h7777_7777;
        @(negedge CLK);
        check("halt_ren", 32'(ram_REN), 32'd1);
        dREN = 1'b0; halt = 1'b1; iREN = 1'b1; iaddr = 32'h0000_0900;
        wait_hit(1'b1, 10, cyc_d);
        check("halt_dload", dload, 32'h7777_7777);
        for (int k = 0; k < 5; k++) begin
            @(negedge CLK);
            check("halt_no_strobe", 32'({ram_REN, ram_WEN}), 32'd0);
        end
        halt = 1'b0; ram_data = 32'h9999_0000; ram_lat = 1;
        @(negedge CLK);
        check("halt_release_addr", ram_addr, 32'h0000_0900);
        check("halt_release_ren", 32'(ram_REN), 32'd1);
        iREN = 1'b0;
        wait_hit(1'b0, 10, cyc_i);
        check("halt_release_iload", iload, 32'h9999_0000);
        repeat (2) @(negedge CLK);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/mem_arbiter.md
Name: mem_arbiter

Overview:
- Shares one single-port, variable-latency RAM between the datapath's instruction-fetch port and data (load/store) port.
- Arbitrates between the two ports and registers the RAM transaction.
- Returns a one-cycle hit plus load data to the winning requester; ihit/dhit drive the pipeline enables.
- Sits between datapath and RAM.

Parameters:
- WORD_W, 32, data/address width.
- MAX_DSTREAK, 4, consecutive data grants allowed while an instruction request waits; then instruction is forced. Legal range 1..15.

Ports:
- CLK  in  1  clock, rising edge
- RST  in  1  asynchronous, active-high reset
- iREN  in  1  instruction read request
- iaddr  in  WORD_W  instruction address
- iload  out  WORD_W  instruction read data, valid while ihit
- ihit  out  1  one-cycle instruction completion pulse
- dREN  in  1  data read request
- dWEN  in  1  data write request
- daddr  in  WORD_W  data address
- dstore  in  WORD_W  store data
- dload  out  WORD_W  load data, valid while dhit
- dhit  out  1  one-cycle data completion pulse
- halt  in  1  stop issuing new grants
- ram_REN  out  1  RAM read strobe
- ram_WEN  out  1  RAM write strobe
- ram_addr  out  WORD_W  RAM address, bits [1:0] forced to 0
- ram_store  out  WORD_W  RAM write data
- ram_load  in  WORD_W  RAM read data, valid with ram_rdy
- ram_rdy  in  1  RAM completes the current access this cycle
- icnt, dcnt, stallcnt  out  32 each  performance counters (see Optional Feature)

Behaviour:
- Reset (async, immediate): state IDLE; ihit, dhit, ram_REN, ram_WEN = 0; iload, dload, ram_addr, ram_store, dstreak = 0.
- States:
  - IDLE: no RAM strobes driven.
  - IBUSY: ram_REN=1.
  - DBUSY: ram_REN or ram_WEN=1.
- IDLE, arbitration:
  - A requester is eligible if its request is high, its own hit is not high this cycle, and halt=0.
  - Data wins by default.
  - Exception: if iREN is eligible and dstreak==MAX_DSTREAK, instruction wins.
- On grant:
  - Latch address (with [1:0] cleared), store data and op into transaction registers; go to IBUSY or DBUSY.
  - RAM strobes are asserted from the next cycle (registered outputs).
- dREN and dWEN both high: treated as a write.
- dstreak:
  - Increments (saturating at MAX_DSTREAK) on each data grant made while iREN=1.
  - Clears on an instruction grant, and on any IDLE cycle with iREN=0.
- BUSY: strobes, address and store data are held stable until ram_rdy=1.
- On ram_rdy:
  - Next cycle: state IDLE, the matching hit=1 for exactly one cycle.
  - Read: load data (iload or dload) is registered from ram_load and holds until the next completion of that port.
  - Write: dhit pulses and dload is unchanged.
- Minimum latency: grant edge, then 1 cycle BUSY with ram_rdy=1, then hit. Request-to-hit is 3 cycles. Back-to-back transactions are spaced by one IDLE cycle.
- Request withdrawn mid-transaction (pipeline flush): the transaction still completes and the hit still pulses. Writes are never aborted.
- The address is not re-sampled after grant; a changing iaddr or daddr during BUSY has no effect.
- halt: blocks new grants only; an in-flight access completes normally.
- Simultaneous hit and new request from the same port: that port is ineligible this cycle and is granted no earlier than the next cycle.
- Async RST mid-transaction: strobes drop immediately, the transaction is abandoned, no hit is issued.

Optional Feature:
- Macro ARB_PERF_EN.
- Defined:
  - icnt increments on each ihit.
  - dcnt increments on each dhit.
  - stallcnt increments each cycle (iREN|dREN|dWEN)=1 with no hit.
  - All three wrap at 2^32 and clear on RST.
- Undefined: icnt, dcnt and stallcnt are tied to 0 and no counter flops are built. All other behaviour is identical.

Decomposition:
- Shared package arb_types_pkg:
  - enum arb_state_t {IDLE, IBUSY, DBUSY}.
  - enum arb_op_t {OP_READ, OP_WRITE}.
  - Localparam for the dstreak width.
- Sub-module arb_perf_counters: holds the three counters under ARB_PERF_EN. Inputs are ihit, dhit and a stall strobe.

Test Plan:
- iREN=1, iaddr=0x0000_0104, RAM returns ram_load=0xDEAD_BEEF with ram_rdy on its first BUSY cycle -> ram_addr=0x104, ram_REN=1 one cycle after grant; ihit pulses once at cycle 3 with iload=0xDEAD_BEEF.
- iREN and dREN asserted together, RAM 2-cycle latency -> data granted first; dhit, then instruction granted after one IDLE cycle; ihit follows.
- dWEN held high with iREN=1, MAX_DSTREAK=4 -> grants D,D,D,D,I,D…; the fifth grant is instruction; dstreak clears after it.
- dWEN=1, daddr=0x0000_0203, dstore=0x1234_5678, dREN deasserted mid-BUSY -> ram_addr=0x200, ram_WEN held until ram_rdy, dhit pulses, dload unchanged.
- RST asserted during DBUSY -> ram_WEN and ram_REN drop to 0 the same cycle, no dhit, state IDLE after RST releases; with ARB_PERF_EN, all counters read 0.
- halt=1 with iREN=1 pending and an in-flight data read -> dhit completes; no further RAM strobes while halt=1.
